layer_priority_mixer: RTL and testbench
=======================================

// Module: layer_priority_mixer
// PURPOSE
// Pixel-rate priority mixer sitting directly upstream of the palette chip. Takes three tilemap
// layer pixels and one sprite pixel per ce_pixel tick and picks the visible one using
// CPU-programmed priorities. Drives the palette index bus SC consumed by the palette stage.
// Has a 68k-style register port with the same DACKn handshake as the palette chip.
// PARAMETERS
// IDX_W     12  palette index width per source; fixed upper bound 12
// PEN_BITS   4  low index bits forming the pen; pen==0 means transparent
// PORTS
// clk       in   1   system clock
// reset_n   in   1   async active-low reset
// ce_pixel  in   1   pixel clock enable, one clk wide
// Din       in  16   CPU write data
// Dout      out 16   CPU read data
// VA        in   3   register select
// RWn       in   1   1=read, 0=write
// UDSn/LDSn in   1   byte strobes (high/low), active low
// SCEn      in   1   chip select, active low
// DACKn     out  1   data acknowledge, active low
// HSYn/VSYn in   1   syncs aligned with the pixel inputs
// L0,L1,L2  in  12   tilemap layer pixels {colour, pen}
// OBJ       in  12   sprite pixel
// OBJ_PRI   in   2   sprite priority group
// SC        out 15   {src[2:0], index[11:0]}; src: 0=bg, 1=L0, 2=L1, 3=L2, 4=OBJ
// HSYn_o/VSYn_o out 1  syncs delayed to match SC
// BEHAVIOUR
// Reset (async, reset_n low):
//  - All registers 0; SC=0; Dout=0; DACKn=1; HSYn_o=VSYn_o=1; pipeline cleared.
// Registers (16-bit; byte-lane writes, UDSn->[15:8], LDSn->[7:0]):
//  - 0: L0 pri [3:0], L1 pri [7:4], L2 pri [11:8]; [15:12] read 0.
//  - 1: sprite group g priority at [4g+3:4g].
//  - 2: bg index [11:0].
//  - 3: bit0 ENABLE, bit1 BLANK; other bits read 0.
//  - 4-7: read 0; writes ignored.
// Bus cycle:
//  - On the clk where SCEn falls (registered previous SCEn=1, now 0), the block performs the access.
//  - Write: update the strobed byte(s). Read: latch Dout.
//  - DACKn goes 0 on the following clk and is held while SCEn stays low.
//  - DACKn goes 1 on the first clk with SCEn=1. Every address is acked, including unused ones.
// Pixel pipeline (advances only on ce_pixel; latency exactly 2 ticks):
//  - S1: register L0..L2, OBJ, OBJ_PRI, syncs and the current priority registers.
//  - S2: compute the winner and register it into SC; syncs delayed identically.
// Winner selection:
//  - A candidate is a source with a nonzero pen AND a nonzero priority.
//  - Highest priority wins. On a tie, OBJ beats layers, and a lower layer number beats a higher one.
//  - If there is no candidate, SC = {3'd0, bg}.
//  - ENABLE=0 forces SC = {3'd0, bg}.
//  - BLANK=1 with S1 HSYn or VSYn low forces SC = 0.
// Write vs ce_pixel in the same clk: the pixel sampled in S1 that tick uses the old value.
//  The new value applies from the next tick onward.
// reset_n deasserted mid-line: the pipeline restarts from zeros. No spurious DACKn.
// Unsigned 4-bit compares only; no arithmetic overflow is possible.
// TESTING
// 1. Reset, then ENABLE=1, bg=0x123, no writes to 0/1 -> SC=0x0123 two ticks after the first ce_pixel.
// 2. pri L0=2, L1=5, L2=5; pens all nonzero, L1=0x0A1 -> SC={1'b0,2'd2,0x0A1}; L2 loses the tie to L1.
// 3. OBJ_PRI=1, group1 pri=5, L1 pri=5, both opaque -> src=4 (OBJ wins the tie).
//    Set OBJ pen=0 -> src=2.
// 4. Byte write LDSn only, Din=0x00FF to reg 0 (prior 0x0321) -> reads back 0x03FF.
//    DACKn low 1 clk after SCEn falls and high the clk SCEn rises.
// 5. BLANK=1, VSYn low at the input -> SC=0 and VSYn_o low, both 2 ticks later.
//    ENABLE=0 -> bg shown regardless of layers.
// 6. Assert reset_n mid-frame with DACKn low -> DACKn=1 and SC=0 immediately, with no clk edge.

Source files
------------

// File: rtl/layer_priority_mixer.sv
// Pixel-rate priority mixer: three tile layers plus sprites into one palette index.
// Holds a 68k-style register port with the palette chip's DACKn handshake.
module layer_priority_mixer #(
  parameter int IDX_W    = 12,
  parameter int PEN_BITS = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             ce_pixel,
  input  logic [15:0]      Din,
  output logic [15:0]      Dout,
  input  logic [2:0]       VA,
  input  logic             RWn,
  input  logic             UDSn,
  input  logic             LDSn,
  input  logic             SCEn,
  output logic             DACKn,
  input  logic             HSYn,
  input  logic             VSYn,
  input  logic [IDX_W-1:0] L0,
  input  logic [IDX_W-1:0] L1,
  input  logic [IDX_W-1:0] L2,
  input  logic [IDX_W-1:0] OBJ,
  input  logic [1:0]       OBJ_PRI,
  output logic [IDX_W+2:0] SC,
  output logic             HSYn_o,
  output logic             VSYn_o
);

  typedef struct packed {
    logic [IDX_W-1:0] l0;
    logic [IDX_W-1:0] l1;
    logic [IDX_W-1:0] l2;
    logic [IDX_W-1:0] obj;
    logic [1:0]       opri;
    logic             hsyn;
    logic             vsyn;
    logic [11:0]      lpri;
    logic [15:0]      spri;
    logic [IDX_W-1:0] bg;
    logic             en;
    logic             blank;
  } s1_t;

  logic [11:0]      r_lpri;
  logic [15:0]      r_spri;
  logic [IDX_W-1:0] r_bg;
  logic [1:0]       r_ctl;

  logic        sce_q;
  logic        ack_q;
  logic        access;
  logic [15:0] rdata;
  logic [15:0] wdata;

  s1_t              s1;
  logic [3:0]       best;
  logic [2:0]       win_src;
  logic [IDX_W-1:0] win_idx;
  logic [3:0]       opri_v;
  logic [IDX_W+2:0] sc_n;

  assign access = sce_q & ~SCEn;

  always_comb begin
    rdata = 16'h0000;
    case (VA)
      3'd0:    rdata = {4'h0, r_lpri};
      3'd1:    rdata = r_spri;
      3'd2:    rdata = 16'(r_bg);
      3'd3:    rdata = {14'h0, r_ctl};
      default: rdata = 16'h0000;
    endcase
  end

  // Merge the strobed byte lanes into the current readback value.
  always_comb begin
    wdata = rdata;
    if (!UDSn) wdata[15:8] = Din[15:8];
    if (!LDSn) wdata[7:0]  = Din[7:0];
  end

  // sce_q resets low so a cycle in flight across reset is not acked.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sce_q <= 1'b0;
      ack_q <= 1'b0;
      DACKn <= 1'b1;
      Dout  <= 16'h0000;
    end else begin
      sce_q <= SCEn;
      ack_q <= access;
      if (SCEn)       DACKn <= 1'b1;
      else if (ack_q) DACKn <= 1'b0;
      if (access && RWn) Dout <= rdata;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_lpri <= '0;
      r_spri <= '0;
      r_bg   <= '0;
      r_ctl  <= '0;
    end else if (access && !RWn) begin
      case (VA)
        3'd0:    r_lpri <= wdata[11:0];
        3'd1:    r_spri <= wdata;
        3'd2:    r_bg   <= wdata[IDX_W-1:0];
        3'd3:    r_ctl  <= wdata[1:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1      <= '0;
      s1.hsyn <= 1'b1;
      s1.vsyn <= 1'b1;
    end else if (ce_pixel) begin
      s1.l0    <= L0;
      s1.l1    <= L1;
      s1.l2    <= L2;
      s1.obj   <= OBJ;
      s1.opri  <= OBJ_PRI;
      s1.hsyn  <= HSYn;
      s1.vsyn  <= VSYn;
      s1.lpri  <= r_lpri;
      s1.spri  <= r_spri;
      s1.bg    <= r_bg;
      s1.en    <= r_ctl[0];
      s1.blank <= r_ctl[1];
    end
  end

  // Strict '>' in OBJ, L0, L1, L2 order gives the tie-break for free.
  always_comb begin
    best    = 4'd0;
    win_src = 3'd0;
    win_idx = s1.bg;
    opri_v  = s1.spri[{s1.opri, 2'b00} +: 4];
    if (s1.obj[PEN_BITS-1:0] != '0 && opri_v > best) begin
      best    = opri_v;
      win_src = 3'd4;
      win_idx = s1.obj;
    end
    if (s1.l0[PEN_BITS-1:0] != '0 && s1.lpri[3:0] > best) begin
      best    = s1.lpri[3:0];
      win_src = 3'd1;
      win_idx = s1.l0;
    end
    if (s1.l1[PEN_BITS-1:0] != '0 && s1.lpri[7:4] > best) begin
      best    = s1.lpri[7:4];
      win_src = 3'd2;
      win_idx = s1.l1;
    end
    if (s1.l2[PEN_BITS-1:0] != '0 && s1.lpri[11:8] > best) begin
      best    = s1.lpri[11:8];
      win_src = 3'd3;
      win_idx = s1.l2;
    end
    if (s1.blank && (!s1.hsyn || !s1.vsyn))
      sc_n = '0;
    else if (!s1.en)
      sc_n = {3'd0, s1.bg};
    else
      sc_n = {win_src, win_idx};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      SC     <= '0;
      HSYn_o <= 1'b1;
      VSYn_o <= 1'b1;
    end else if (ce_pixel) begin
      SC     <= sc_n;
      HSYn_o <= s1.hsyn;
      VSYn_o <= s1.vsyn;
    end
  end

endmodule

// File: tb/tb_layer_priority_mixer.sv
// Self-checking bench for layer_priority_mixer: directed cases plus
// randomized pixels checked against a rule-level reference model.
module tb_layer_priority_mixer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        ce_pixel = 1'b0;
  logic [15:0] Din = '0;
  logic [15:0] Dout;
  logic [2:0]  VA = '0;
  logic        RWn = 1'b1;
  logic        UDSn = 1'b1;
  logic        LDSn = 1'b1;
  logic        SCEn = 1'b1;
  logic        DACKn;
  logic        HSYn = 1'b1;
  logic        VSYn = 1'b1;
  logic [11:0] L0 = '0;
  logic [11:0] L1 = '0;
  logic [11:0] L2 = '0;
  logic [11:0] OBJ = '0;
  logic [1:0]  OBJ_PRI = '0;
  logic [14:0] SC;
  logic        HSYn_o;
  logic        VSYn_o;

  layer_priority_mixer #(.IDX_W(12), .PEN_BITS(4)) dut (
    .clk(clk), .reset_n(reset_n), .ce_pixel(ce_pixel),
    .Din(Din), .Dout(Dout), .VA(VA), .RWn(RWn),
    .UDSn(UDSn), .LDSn(LDSn), .SCEn(SCEn), .DACKn(DACKn),
    .HSYn(HSYn), .VSYn(VSYn),
    .L0(L0), .L1(L1), .L2(L2), .OBJ(OBJ), .OBJ_PRI(OBJ_PRI),
    .SC(SC), .HSYn_o(HSYn_o), .VSYn_o(VSYn_o)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [15:0] mreg [4];
  logic [16:0] q [$];
  logic [15:0] rd;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: {HSYn, VSYn, SC} the current inputs and registers should produce.
  function automatic logic [16:0] model();
    logic [3:0]  pri [4];
    logic [11:0] idx [4];
    logic [2:0]  src [4];
    logic [3:0]  top;
    logic [14:0] sc;
    int          win;
    idx[0] = OBJ; idx[1] = L0; idx[2] = L1; idx[3] = L2;
    src[0] = 3'd4; src[1] = 3'd1; src[2] = 3'd2; src[3] = 3'd3;
    pri[0] = mreg[1][int'(OBJ_PRI)*4 +: 4];
    pri[1] = mreg[0][3:0];
    pri[2] = mreg[0][7:4];
    pri[3] = mreg[0][11:8];
    top = 0;
    for (int i = 0; i < 4; i++)
      if (idx[i][3:0] != 0 && pri[i] > top) top = pri[i];
    win = -1;
    for (int i = 3; i >= 0; i--)
      if (top != 0 && idx[i][3:0] != 0 && pri[i] == top) win = i;
    sc = {3'd0, mreg[2][11:0]};
    if (mreg[3][0] && win >= 0) sc = {src[win], idx[win]};
    if (mreg[3][1] && (!HSYn || !VSYn)) sc = '0;
    return {HSYn, VSYn, sc};
  endfunction

  function automatic logic [15:0] mread(input logic [2:0] a);
    return (a < 4) ? mreg[a[1:0]] : 16'h0000;
  endfunction

  task automatic mwrite(input logic [2:0] a, input logic u, input logic l,
                        input logic [15:0] d);
    logic [15:0] m;
    if (a >= 4) return;
    m = mreg[a[1:0]];
    if (!u) m[15:8] = d[15:8];
    if (!l) m[7:0] = d[7:0];
    case (a)
      3'd0: m &= 16'h0FFF;
      3'd2: m &= 16'h0FFF;
      3'd3: m &= 16'h0003;
      default: ;
    endcase
    mreg[a[1:0]] = m;
  endtask

  task automatic check_pop(input string tag);
    logic [16:0] e;
    e = q.pop_front();
    chk({tag, "_sc"}, 32'(SC), 32'(e[14:0]));
    chk({tag, "_hs"}, 32'(HSYn_o), 32'(e[16]));
    chk({tag, "_vs"}, 32'(VSYn_o), 32'(e[15]));
  endtask

  task automatic tick();
    @(negedge clk);
    ce_pixel = 1'b1;
    q.push_back(model());
    @(posedge clk);
    #1;
    ce_pixel = 1'b0;
    check_pop("tick");
  endtask

  task automatic bus(input logic [2:0] a, input logic rw, input logic u,
                     input logic l, input logic [15:0] d, input logic ce,
                     output logic [15:0] r);
    logic [15:0] exp;
    @(negedge clk);
    VA = a; RWn = rw; UDSn = u; LDSn = l; Din = d; SCEn = 1'b0;
    if (ce) begin
      ce_pixel = 1'b1;
      q.push_back(model());
    end
    exp = mread(a);
    if (!rw) mwrite(a, u, l, d);
    @(posedge clk);
    #1;
    ce_pixel = 1'b0;
    if (ce) check_pop("buswr_ce");
    chk("dack_first", 32'(DACKn), 32'd1);
    @(posedge clk);
    #1;
    chk("dack_low", 32'(DACKn), 32'd0);
    if (rw) chk("read", 32'(Dout), 32'(exp));
    r = Dout;
    @(negedge clk);
    SCEn = 1'b1; RWn = 1'b1; UDSn = 1'b1; LDSn = 1'b1;
    @(posedge clk);
    #1;
    chk("dack_rise", 32'(DACKn), 32'd1);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) mreg[i] = '0;
    q.delete();
    q.push_back(17'h18000);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    model_reset();
    #22;
    chk("rst_sc", 32'(SC), 32'd0);
    chk("rst_dout", 32'(Dout), 32'd0);
    chk("rst_dack", 32'(DACKn), 32'd1);
    chk("rst_hs", 32'(HSYn_o), 32'd1);
    chk("rst_vs", 32'(VSYn_o), 32'd1);
    @(negedge clk);
    reset_n = 1'b1;

    bus(3'd3, 1'b0, 1'b0, 1'b0, 16'h0001, 1'b0, rd);
    bus(3'd2, 1'b0, 1'b0, 1'b0, 16'h0123, 1'b0, rd);
    tick();
    tick();
    chk("t1_bg", 32'(SC), 32'h0123);

    bus(3'd2, 1'b0, 1'b0, 1'b0, 16'h0456, 1'b1, rd);
    tick();
    chk("samecyc_old", 32'(SC), 32'h0123);
    tick();
    chk("samecyc_new", 32'(SC), 32'h0456);

    bus(3'd0, 1'b0, 1'b0, 1'b0, 16'h0552, 1'b0, rd);
    L0 = 12'h011; L1 = 12'h0A1; L2 = 12'h0B2;
    tick();
    tick();
    chk("t2_tie_l1", 32'(SC), 32'h20A1);

    bus(3'd1, 1'b0, 1'b0, 1'b0, 16'h0050, 1'b0, rd);
    OBJ_PRI = 2'd1; OBJ = 12'h0C7;
    tick();
    tick();
    chk("t3_obj", 32'(SC), 32'h40C7);
    OBJ = 12'h0C0;
    tick();
    tick();
    chk("t3_objclr", 32'(SC), 32'h20A1);

    bus(3'd0, 1'b0, 1'b0, 1'b0, 16'h0321, 1'b0, rd);
    bus(3'd0, 1'b0, 1'b1, 1'b0, 16'h00FF, 1'b0, rd);
    bus(3'd0, 1'b1, 1'b1, 1'b1, 16'h0000, 1'b0, rd);
    chk("t4_bytewr", 32'(rd), 32'h03FF);
    bus(3'd6, 1'b0, 1'b0, 1'b0, 16'hFFFF, 1'b0, rd);
    bus(3'd6, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, rd);
    chk("unused_rd", 32'(rd), 32'h0000);

    bus(3'd3, 1'b0, 1'b0, 1'b0, 16'hFFFF, 1'b0, rd);
    VSYn = 1'b0;
    tick();
    tick();
    chk("t5_blank", 32'(SC), 32'h0000);
    chk("t5_vsyn", 32'(VSYn_o), 32'd0);
    VSYn = 1'b1;
    bus(3'd3, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, rd);
    tick();
    tick();
    chk("t5_disable", 32'(SC), 32'h0456);

    for (int r = 0; r < 8; r++) begin
      bus(3'd0, 1'b0, 1'b0, 1'b0, 16'($urandom), 1'b0, rd);
      bus(3'd1, 1'b0, 1'b0, 1'b0, 16'($urandom), 1'b0, rd);
      bus(3'd2, 1'b0, 1'b0, 1'b0, 16'($urandom), 1'b0, rd);
      bus(3'd3, 1'b0, 1'b0, 1'b0, 16'($urandom_range(0, 3)), 1'b0, rd);
      bus(3'($urandom_range(0, 7)), 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, rd);
      for (int t = 0; t < 20; t++) begin
        L0 = 12'($urandom); if ($urandom_range(0, 2) == 0) L0[3:0] = 4'h0;
        L1 = 12'($urandom); if ($urandom_range(0, 2) == 0) L1[3:0] = 4'h0;
        L2 = 12'($urandom); if ($urandom_range(0, 2) == 0) L2[3:0] = 4'h0;
        OBJ = 12'($urandom); if ($urandom_range(0, 2) == 0) OBJ[3:0] = 4'h0;
        OBJ_PRI = 2'($urandom);
        HSYn = ($urandom_range(0, 7) != 0);
        VSYn = ($urandom_range(0, 7) != 0);
        tick();
      end
    end
    HSYn = 1'b1; VSYn = 1'b1;

    bus(3'd3, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, rd);
    bus(3'd2, 1'b0, 1'b0, 1'b0, 16'h05A5, 1'b0, rd);
    tick();
    tick();
    chk("pre_rst_bg", 32'(SC), 32'h05A5);
    @(negedge clk);
    VA = 3'd3; RWn = 1'b1; SCEn = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk("t6_dack_low", 32'(DACKn), 32'd0);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t6_dack", 32'(DACKn), 32'd1);
    chk("t6_sc", 32'(SC), 32'd0);
    chk("t6_dout", 32'(Dout), 32'd0);
    model_reset();
    SCEn = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk("t6_noack", 32'(DACKn), 32'd1);
    tick();
    tick();
    chk("t6_restart", 32'(SC), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
